// File: rtl/alu_sel_a.sv
// Operand-A select decode for the RV32I datapath, plus a one-hot integrity monitor on CODE.
// Build with ALU_SEL_A_ONEHOT_CHECK_EN defined to include the monitor flops.
module alu_sel_a (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] CODE,
  output logic       alu_sel_A,
  output logic       code_valid,
  output logic       code_err,
  output logic [7:0] err_count
);

  localparam int unsigned CODE_W = 10;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic code_onehot;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  always_comb begin
    code_onehot = (CODE != '0) && ((CODE & (CODE - CODE_W'(1))) == '0);
  end

  // Only J and AUIPC take PC as operand A; LUI/CSR and invalid codes drive 0.
  always_comb begin
    alu_sel_A = code_onehot && (CODE[0] || CODE[3]);
  end

`ifdef ALU_SEL_A_ONEHOT_CHECK_EN

  always_comb begin
    code_valid = code_onehot;
  end

  // Sticky error flag and saturating counter of invalid samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_err  <= 1'b0;
      err_count <= '0;
    end else if (!code_onehot) begin
      code_err <= 1'b1;
      if (err_count != CNT_MAX) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

`else

  logic unused_ok;

  always_comb begin
    code_valid = 1'b1;
    code_err   = 1'b0;
    err_count  = '0;
    unused_ok  = &{1'b0, clk, rst};
  end

`endif

endmodule

// File: tb/tb_alu_sel_a.sv
// Self-checking bench for alu_sel_a: directed plan steps plus randomized codes vs a reference model.
// Expectations follow the ALU_SEL_A_ONEHOT_CHECK_EN build setting.
module tb_alu_sel_a;

`ifdef ALU_SEL_A_ONEHOT_CHECK_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [9:0] code;
  logic       alu_sel_A;
  logic       code_valid;
  logic       code_err;
  logic [7:0] err_count;

  int n_checks;
  int n_err;

  // reference model state
  bit m_err;
  int m_cnt;

  alu_sel_a dut (
    .clk        (clk),
    .rst        (rst),
    .CODE       (code),
    .alu_sel_A  (alu_sel_A),
    .code_valid (code_valid),
    .code_err   (code_err),
    .err_count  (err_count)
  );

  function automatic int popcnt(input logic [9:0] c);
    int n = 0;
    for (int i = 0; i < 10; i++) n += int'(c[i]);
    return n;
  endfunction

  // Class-level view: one class selected, and that class is J (0) or AUIPC (3).
  function automatic bit ref_sel(input logic [9:0] c);
    int idx = -1;
    if (popcnt(c) != 1) return 1'b0;
    for (int i = 0; i < 10; i++) if (c[i]) idx = i;
    return (idx == 0) || (idx == 3);
  endfunction

  function automatic bit ref_valid(input logic [9:0] c);
    return MON ? (popcnt(c) == 1) : 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input string tag);
    chk({tag, "_sel"},   32'(alu_sel_A),  32'(ref_sel(code)));
    chk({tag, "_valid"}, 32'(code_valid), 32'(ref_valid(code)));
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_err"}, 32'(code_err),  32'(m_err));
    chk({tag, "_cnt"}, 32'(err_count), 32'(m_cnt));
  endtask

  // One clock period; model samples CODE at the rising edge.
  task automatic tick();
    #4 clk = 1'b1;
    if (MON && !rst && popcnt(code) != 1) begin
      m_err = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    #5 clk = 1'b0;
    #1;
  endtask

  task automatic do_reset_pulse();
    #3 rst = 1'b1;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  function automatic logic [9:0] rand_code();
    logic [9:0] c;
    if ($urandom_range(1, 0) == 1) c = 10'(1) << $urandom_range(9, 0);
    else c = 10'($urandom);
    return c;
  endfunction

  initial begin
    n_checks = 0;
    n_err    = 0;
    clk      = 1'b0;
    rst      = 1'b1;
    code     = 10'b0000000001;
    m_err    = 1'b0;
    m_cnt    = 0;

    // reset state, comb path live during reset
    #10;
    chk_regs("reset");
    chk_comb("reset_comb");
    rst = 1'b0;
    #10;

    // one-hot sweep without clock edges
    for (int i = 0; i < 10; i++) begin
      code = 10'(1) << i;
      #10;
      chk($sformatf("sweep%0d_sel", i), 32'(alu_sel_A), 32'((i == 0) || (i == 3)));
      chk($sformatf("sweep%0d_valid", i), 32'(code_valid), 32'(1));
    end
    chk_regs("sweep_regs");

    // non-one-hot inputs
    code = 10'b0000000000;
    #10;
    chk("zero_sel", 32'(alu_sel_A), 32'(0));
    chk("zero_valid", 32'(code_valid), 32'(!MON));
    code = 10'b0000001001;
    #10;
    chk("two_sel", 32'(alu_sel_A), 32'(0));
    chk("two_valid", 32'(code_valid), 32'(!MON));
    tick();
    chk("first_err", 32'(code_err), 32'(MON));
    chk("first_cnt", 32'(err_count), 32'(MON ? 1 : 0));

    // saturation while holding an invalid code
    for (int i = 0; i < 300; i++) begin
      tick();
      chk_regs($sformatf("sat%0d", i));
    end
    chk("sat_cnt", 32'(err_count), 32'(MON ? 255 : 0));
    chk("sat_err", 32'(code_err), 32'(MON));

    // asynchronous reset between edges
    do_reset_pulse();
    #1;
    chk("async_rst_err", 32'(code_err), 32'(0));
    chk("async_rst_cnt", 32'(err_count), 32'(0));
    chk_comb("rst_comb");
    code = 10'b0010000000;
    #5 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_regs($sformatf("post_rst%0d", i));
    end

    // alternate invalid/valid
    for (int i = 0; i < 4; i++) begin
      code = (i % 2 == 0) ? 10'b1100000000 : 10'b0000001000;
      #2;
      chk_comb($sformatf("alt%0d", i));
      tick();
    end
    chk("alt_cnt", 32'(err_count), 32'(MON ? 2 : 0));
    chk("alt_err", 32'(code_err), 32'(MON));

    // randomized codes with occasional resets
    for (int i = 0; i < 400; i++) begin
      code = rand_code();
      #2;
      chk_comb($sformatf("rnd%0d", i));
      if ($urandom_range(39, 0) == 0) begin
        do_reset_pulse();
        #1;
        chk_regs($sformatf("rnd_rst%0d", i));
        #2 rst = 1'b0;
      end
      tick();
      chk_regs($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sel_a.md
# alu_sel_a

Control-unit decode block that selects ALU operand A for the RV32I datapath. It decodes the one-hot instruction-class vector `CODE` into `alu_sel_A`, where 1 selects PC and 0 selects rs1. Alongside this it runs a clocked one-hot integrity monitor for `CODE`. It sits between the opcode classifier and the operand-A mux in front of the ALU.

## Interface
- No parameters.
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock; used only by the integrity monitor.
- `rst`  in  1  asynchronous, active-high reset.
- `CODE`  in  10  one-hot instruction class. Bit mapping:
  - bit0 J
  - bit1 I-JALR
  - bit2 U-LUI
  - bit3 U-AUIPC
  - bit4 B
  - bit5 R
  - bit6 S
  - bit7 I-ALU
  - bit8 I-LOAD
  - bit9 I-CSR
- `alu_sel_A`  out  1  operand-A select (1 = PC, 0 = rs1); combinational.
- `code_valid`  out  1  combinational; 1 when exactly one bit of `CODE` is set.
- `code_err`  out  1  registered, sticky; set when an invalid `CODE` is sampled.
- `err_count`  out  8  registered, saturating count of invalid samples.

## Operation
- Decode of `alu_sel_A`, purely combinational with no clock dependence:
  - `CODE` = J (0000000001) -> 1
  - `CODE` = AUIPC (0000001000) -> 1
  - `CODE` = JALR, B, R, S, I-ALU, I-LOAD -> 0
  - `CODE` = LUI, CSR -> 0. Operand A is unused for these classes; the block drives 0 deterministically and never X.
- Any non-one-hot `CODE` (all zeros, or two or more bits set) -> `alu_sel_A` = 0 and `code_valid` = 0.
- `code_valid` = 1 iff `popcount(CODE)` == 1.
- Integrity monitor, on each rising `clk` edge when `rst` = 0:
  - If `code_valid` = 0: `code_err` <= 1, and `err_count` increments, saturating at 255.
  - Otherwise: no change.
- `code_err` clears only on reset.
- Reset (`rst` = 1) asynchronously forces `code_err` = 0 and `err_count` = 0, regardless of `clk`.
- Reset never affects `alu_sel_A` or `code_valid`; these follow `CODE` during reset.

## Timing
- `alu_sel_A` and `code_valid`: zero-cycle latency, settled within the same cycle `CODE` changes. The bench checks them 10 ns after applying `CODE`, with no clock edge required.
- `code_err` / `err_count`: update on the first rising edge after an invalid `CODE` is applied. The counter adds one per edge while the input stays invalid.
- Reset values: `code_err` = 0, `err_count` = 0.
- Reset assertion mid-count clears both outputs immediately. The first post-release edge samples normally.
- Saturation: at `err_count` = 255, further invalid samples hold 255 and `code_err` stays 1.

## Configuration
- Macro `ALU_SEL_A_ONEHOT_CHECK_EN`.
- Defined: the integrity monitor is built as described above.
- Undefined: `code_valid` is tied to 1, `code_err` to 0, and `err_count` to 0, and no flops are inferred. `alu_sel_A` decode is identical in both builds, including 0 for non-one-hot inputs.

## Test plan
- Sweep all ten one-hot `CODE` values, 10 ns apart, with no clock:
  - J -> 1
  - JALR -> 0
  - LUI -> 0
  - AUIPC -> 1
  - B, R, S, I-ALU, I-LOAD -> 0
  - CSR -> 0
  - `code_valid` = 1 throughout.
- `CODE` = 0000000000, then 0000001001 -> `alu_sel_A` = 0 and `code_valid` = 0 combinationally. After one `clk` edge: `code_err` = 1, `err_count` = 1.
- Hold an invalid `CODE` for 300 edges -> `err_count` saturates at 255 and `code_err` = 1.
- After errors exist, apply `rst` = 1 between clock edges -> `code_err` = 0 and `err_count` = 0 immediately. With a valid `CODE` applied afterwards, the counters stay 0.
- Alternate valid and invalid `CODE` for 4 edges (invalid, valid, invalid, valid) -> `err_count` = 2, `code_err` = 1.
- Build without `ALU_SEL_A_ONEHOT_CHECK_EN` and apply an invalid `CODE` with clocks running -> `code_valid` = 1, `code_err` = 0, `err_count` = 0, `alu_sel_A` = 0.
